cnn_frame_sequencer: RTL and testbench

Parametrised frame-level sequencer for the lane-detection CNN pipeline. It drives the feature extractor, flatten buffer and fully connected layer through one frame. It counts pixels and features against configurable frame geometry and enforces a separate timeout per stage. Each frame result, good or failed, is returned with a status code over a valid/ready handshake, with support for back-to-back and continuous frames.

---
 rtl/cnn_seq_pkg.sv | 22 ++
 rtl/cnn_stage_timer.sv | 28 ++
 rtl/cnn_frame_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_cnn_frame_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_seq_pkg.sv
// Shared types and constants for the lane-detection CNN frame sequencer.
package cnn_seq_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFeat    = 3'd1,
        StWaitBuf = 3'd2,
        StFc      = 3'd3,
        StOut     = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        StatOk         = 2'd0,
        StatFeTimeout  = 2'd1,
        StatBufTimeout = 2'd2,
        StatFcTimeout  = 2'd3
    } seq_status_e;

    localparam logic [15:0] DbgTagHi = 16'hDEAD;
    localparam logic [15:0] DbgTagLo = 16'hBEEF;

endpackage

// File: rtl/cnn_stage_timer.sv
// Per-stage cycle timer: cleared on state entry, flags the cycle it reaches the limit.
module cnn_stage_timer #(
    parameter int unsigned TMR_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [TMR_W-1:0] limit_i,
    output logic             expired_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr_i ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == limit_i);

endmodule

// File: rtl/cnn_frame_sequencer.sv
// Frame-level sequencer for the CNN pipeline: FEAT -> WAIT_BUF -> FC -> OUT with per-stage
// timeouts. Define CNN_SEQ_DEBUG_TAG_EN to tag timeout results with 0xDEADBEEF and pix_cnt.
module cnn_frame_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int unsigned PIX_PER_FRAME  = 1024,
    parameter int unsigned FEAT_PER_FRAME = 225,
    parameter int unsigned RES_W          = 48,
    parameter int unsigned TMR_W          = 17,
    parameter int unsigned FE_TIMEOUT     = 50000,
    parameter int unsigned BUF_TIMEOUT    = 10000,
    parameter int unsigned FC_TIMEOUT     = 100000,
    parameter int unsigned FRM_W          = 16,
    parameter int unsigned AUTO_RESTART   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             pixel_valid_i,
    output logic             fe_start_o,
    input  logic             fe_valid_i,
    input  logic             fe_done_i,
    input  logic             buf_full_i,
    output logic             fc_start_o,
    input  logic             fc_valid_i,
    input  logic [RES_W-1:0] fc_data_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [RES_W-1:0] res_data_o,
    output logic [1:0]       res_status_o,
    output logic [15:0]      feat_cnt_o,
    output logic [FRM_W-1:0] frame_cnt_o,
    output logic             busy_o,
    output logic [2:0]       state_o
);

    localparam logic [31:0] PixMax = 32'(PIX_PER_FRAME);

    seq_state_e       state_q, state_d;
    seq_status_e      res_status_q, res_status_d;
    logic [31:0]      pix_cnt_q, pix_cnt_d;
    logic [15:0]      feat_cnt_q, feat_cnt_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [RES_W-1:0] res_data_q, res_data_d;
    logic             pending_q, pending_d;
    logic             fe_start_q, fe_start_d;
    logic             fc_start_q, fc_start_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;

    logic [TMR_W-1:0] tmr_limit;
    logic             tmr_expired;
    logic [RES_W-1:0] timeout_data;

`ifdef CNN_SEQ_DEBUG_TAG_EN
    assign timeout_data = RES_W'({DbgTagHi, DbgTagLo, pix_cnt_q[15:0]});
`else
    assign timeout_data = '0;
`endif

    always_comb begin
        tmr_limit = '1;
        case (state_q)
            StFeat:    tmr_limit = TMR_W'(FE_TIMEOUT);
            StWaitBuf: tmr_limit = TMR_W'(BUF_TIMEOUT);
            StFc:      tmr_limit = TMR_W'(FC_TIMEOUT);
            default:   tmr_limit = '1;
        endcase
    end

    cnn_stage_timer #(
        .TMR_W (TMR_W)
    ) u_stage_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_d != state_q),
        .limit_i   (tmr_limit),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        res_status_d = res_status_q;
        res_data_d   = res_data_q;
        pix_cnt_d    = pix_cnt_q;
        feat_cnt_d   = feat_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        pending_d    = pending_q;

        if (state_q == StFeat && pixel_valid_i && pix_cnt_q != PixMax) begin
            pix_cnt_d = pix_cnt_q + 32'd1;
        end
        if ((state_q == StFeat || state_q == StWaitBuf) && fe_valid_i && feat_cnt_q != 16'hFFFF) begin
            feat_cnt_d = feat_cnt_q + 16'd1;
        end

        if (abort_i) begin
            state_d   = StIdle;
            pending_d = 1'b0;
        end else begin
            if (state_q != StIdle && start_i) begin
                pending_d = 1'b1;
            end
            // Normal exits are tested before the timer so they win a same-cycle tie.
            case (state_q)
                StIdle: begin
                    if (start_i) state_d = StFeat;
                end
                StFeat: begin
                    if (pix_cnt_q == PixMax && fe_done_i) begin
                        state_d = StWaitBuf;
                    end else if (tmr_expired) begin
                        state_d      = StOut;
                        res_status_d = StatFeTimeout;
                        res_data_d   = timeout_data;
                    end
                end
                StWaitBuf: begin
                    if (buf_full_i) begin
                        state_d = StFc;
                    end else if (tmr_expired) begin
                        state_d      = StOut;
                        res_status_d = StatBufTimeout;
                        res_data_d   = timeout_data;
                    end
                end
                StFc: begin
                    if (fc_valid_i) begin
                        state_d      = StOut;
                        res_status_d = StatOk;
                        res_data_d   = fc_data_i;
                    end else if (tmr_expired) begin
                        state_d      = StOut;
                        res_status_d = StatFcTimeout;
                        res_data_d   = timeout_data;
                    end
                end
                StOut: begin
                    if (res_ready_i) begin
                        if (res_status_q == StatOk) frame_cnt_d = frame_cnt_q + 1'b1;
                        // A request arriving in the handshake cycle itself is honoured too.
                        if (AUTO_RESTART != 0 || pending_q || start_i) begin
                            state_d = StFeat;
                        end else begin
                            state_d = StIdle;
                        end
                        pending_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (state_d == StFeat && state_q != StFeat) begin
            pix_cnt_d    = '0;
            feat_cnt_d   = '0;
            res_status_d = StatOk;
            pending_d    = 1'b0;
        end

        fe_start_d  = (state_d == StFeat) && (state_q != StFeat);
        fc_start_d  = (state_d == StFc) && (state_q != StFc);
        res_valid_d = (state_d == StOut);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            res_status_q <= StatOk;
            res_data_q   <= '0;
            pix_cnt_q    <= '0;
            feat_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            pending_q    <= 1'b0;
            fe_start_q   <= 1'b0;
            fc_start_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            res_status_q <= res_status_d;
            res_data_q   <= res_data_d;
            pix_cnt_q    <= pix_cnt_d;
            feat_cnt_q   <= feat_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            pending_q    <= pending_d;
            fe_start_q   <= fe_start_d;
            fc_start_q   <= fc_start_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign fe_start_o   = fe_start_q;
    assign fc_start_o   = fc_start_q;
    assign res_valid_o  = res_valid_q;
    assign res_data_o   = res_data_q;
    assign res_status_o = res_status_q;
    assign feat_cnt_o   = feat_cnt_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign busy_o       = busy_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed/randomised bench for cnn_frame_sequencer; honours CNN_SEQ_DEBUG_TAG_EN.
module tb_cnn_frame_sequencer;

`ifdef CNN_SEQ_DEBUG_TAG_EN
    localparam bit DbgEn = 1'b1;
`else
    localparam bit DbgEn = 1'b0;
`endif

    logic        clk, rst;
    logic        start, abort, pixel_valid, fe_valid, fe_done, buf_full, fc_valid, res_ready;
    logic [47:0] fc_data;

    logic        fe_start, fc_start, res_valid, busy;
    logic [47:0] res_data;
    logic [1:0]  res_status;
    logic [15:0] feat_cnt, frame_cnt;
    logic [2:0]  state;

    logic        start_a, ready_a;
    logic        fe_start_a, fc_start_a, res_valid_a, busy_a;
    logic [47:0] res_data_a;
    logic [1:0]  res_status_a;
    logic [15:0] feat_cnt_a, frame_cnt_a;
    logic [2:0]  state_a;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int fe_pulses_a = 0;

    cnn_frame_sequencer #(
        .PIX_PER_FRAME (16), .FEAT_PER_FRAME (9), .RES_W (48), .TMR_W (17),
        .FE_TIMEOUT (40), .BUF_TIMEOUT (20), .FC_TIMEOUT (30), .FRM_W (16), .AUTO_RESTART (0)
    ) u_dut (
        .clk (clk), .rst (rst), .start_i (start), .abort_i (abort),
        .pixel_valid_i (pixel_valid), .fe_start_o (fe_start), .fe_valid_i (fe_valid),
        .fe_done_i (fe_done), .buf_full_i (buf_full), .fc_start_o (fc_start),
        .fc_valid_i (fc_valid), .fc_data_i (fc_data), .res_valid_o (res_valid),
        .res_ready_i (res_ready), .res_data_o (res_data), .res_status_o (res_status),
        .feat_cnt_o (feat_cnt), .frame_cnt_o (frame_cnt), .busy_o (busy), .state_o (state)
    );

    cnn_frame_sequencer #(
        .PIX_PER_FRAME (16), .FEAT_PER_FRAME (9), .RES_W (48), .TMR_W (17),
        .FE_TIMEOUT (40), .BUF_TIMEOUT (20), .FC_TIMEOUT (30), .FRM_W (16), .AUTO_RESTART (1)
    ) u_dut_auto (
        .clk (clk), .rst (rst), .start_i (start_a), .abort_i (abort),
        .pixel_valid_i (pixel_valid), .fe_start_o (fe_start_a), .fe_valid_i (fe_valid),
        .fe_done_i (fe_done), .buf_full_i (buf_full), .fc_start_o (fc_start_a),
        .fc_valid_i (fc_valid), .fc_data_i (fc_data), .res_valid_o (res_valid_a),
        .res_ready_i (ready_a), .res_data_o (res_data_a), .res_status_o (res_status_a),
        .feat_cnt_o (feat_cnt_a), .frame_cnt_o (frame_cnt_a), .busy_o (busy_a),
        .state_o (state_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (fe_start_a) fe_pulses_a++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected timeout payload from the pixel count reached before the timeout.
    function automatic logic [47:0] exp_to(input int pix);
        return DbgEn ? (48'hDEAD_BEEF_0000 | 48'(pix & 16'hFFFF)) : 48'd0;
    endfunction

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_state", state, 1);
        check("start_fe_pulse", fe_start, 1);
        check("start_busy_status", {busy, res_status}, 3'b100);
    endtask

    // Entered at the first FEAT cycle. mode: 0 ok, 2 buf timeout, 3 fc timeout,
    // 4 stop in WAIT_BUF, 5 abort coinciding with fc_valid.
    task automatic run_frame(input int mode, input int buf_wait, input logic [47:0] d);
        int nfeat = 0;
        for (int p = 0; p < 18; p++) begin
            if ($urandom_range(0, 1) == 1) tick();
            pixel_valid = 1'b1;
            fe_valid    = 1'($urandom_range(0, 1));
            if (fe_valid) nfeat++;
            tick();
            pixel_valid = 1'b0;
            fe_valid    = 1'b0;
        end
        check("fe_start_single", fe_start, 0);
        check("still_feat", state, 1);
        fe_done = 1'b1;
        tick();
        fe_done = 1'b0;
        check("wait_buf_entry", state, 2);
        check("feat_cnt_feat", feat_cnt, nfeat);
        if (mode == 4) return;
        if (mode == 2) begin
            buf_full = 1'b0;
            repeat (20) tick();
            check("buf_last_cycle", state, 2);
            tick();
            check("buf_to_out", {res_valid, res_status, res_data}, {1'b1, 2'd2, exp_to(16)});
            return;
        end
        for (int i = 0; i < buf_wait; i++) begin
            fe_valid = 1'($urandom_range(0, 1));
            if (fe_valid) nfeat++;
            tick();
        end
        fe_valid = 1'b0;
        buf_full = 1'b1;
        tick();
        buf_full = 1'b0;
        check("fc_entry", {state, fc_start}, {3'd3, 1'b1});
        check("feat_cnt_total", feat_cnt, nfeat);
        if (mode == 3) begin
            repeat (30) tick();
            check("fc_last_cycle", {state, fc_start}, {3'd3, 1'b0});
            tick();
            check("fc_to_out", {res_valid, res_status, res_data}, {1'b1, 2'd3, exp_to(16)});
            return;
        end
        repeat ($urandom_range(0, 4)) tick();
        fc_valid = 1'b1;
        fc_data  = d;
        abort    = (mode == 5);
        tick();
        fc_valid = 1'b0;
        abort    = 1'b0;
        if (mode == 5) begin
            check("abort_idle", state, 0);
            for (int i = 0; i < 3; i++) begin
                check("abort_no_valid", res_valid, 0);
                tick();
            end
            check("abort_frame_cnt", frame_cnt, exp_frames);
            return;
        end
        check("ok_out", {state, res_valid, res_status, res_data}, {3'd4, 1'b1, 2'd0, d});
    endtask

    task automatic finish_frame(input int hold, input bit req, input logic [47:0] d,
                                input logic [1:0] st);
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start = req && (i == hold / 2);
            tick();
            start = 1'b0;
            check("hold_stable", {res_valid, res_status, res_data}, {1'b1, st, d});
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        if (st == 2'd0) exp_frames++;
        check("frame_cnt", frame_cnt, exp_frames);
        if (req) check("pending_restart", {state, fe_start, res_valid}, {3'd1, 1'b1, 1'b0});
        else check("return_idle", {state, res_valid, busy}, 5'd0);
    endtask

    task automatic fe_timeout(input int n);
        start_frame();
        for (int i = 0; i < 40; i++) begin
            pixel_valid = (i < n);
            fe_done     = (i == 20);
            tick();
        end
        pixel_valid = 1'b0;
        fe_done     = 1'b0;
        check("fe_last_cycle", {state, res_valid}, {3'd1, 1'b0});
        tick();
        check("fe_to_out", {res_valid, res_status, res_data}, {1'b1, 2'd1, exp_to(n)});
        finish_frame($urandom_range(0, 3), 1'b0, exp_to(n), 2'd1);
    endtask

    initial begin
        logic [47:0] d;
        rst = 1'b1;
        {start, abort, pixel_valid, fe_valid, fe_done, buf_full, fc_valid, res_ready} = '0;
        {start_a, ready_a} = '0;
        fc_data = '0;
        repeat (3) tick();
        check("reset_outputs", {fe_start, fc_start, res_valid, res_data, res_status, feat_cnt,
                                frame_cnt, busy, state}, 0);
        rst = 1'b0;
        tick();

        // Nominal frame with result -5.
        start_frame();
        run_frame(0, $urandom_range(0, 5), 48'hFFFF_FFFF_FFFB);
        finish_frame(0, 1'b0, 48'hFFFF_FFFF_FFFB, 2'd0);

        for (int f = 0; f < 3; f++) begin
            d = {16'($urandom), $urandom};
            start_frame();
            run_frame(0, $urandom_range(0, 19), d);
            finish_frame($urandom_range(0, 3), 1'b0, d, 2'd0);
        end

        fe_timeout(10);
        fe_timeout($urandom_range(0, 15));

        start_frame();
        run_frame(2, 0, '0);
        finish_frame(1, 1'b0, exp_to(16), 2'd2);
        start_frame();
        run_frame(3, 0, '0);
        finish_frame(1, 1'b0, exp_to(16), 2'd3);

        // buf_full on the timeout cycle must still advance normally.
        d = {16'($urandom), $urandom};
        start_frame();
        run_frame(0, 20, d);
        finish_frame(0, 1'b0, d, 2'd0);

        // Backpressure with a queued start, then back-to-back frame.
        d = {16'($urandom), $urandom};
        start_frame();
        run_frame(0, 3, d);
        finish_frame(50, 1'b1, d, 2'd0);
        d = {16'($urandom), $urandom};
        run_frame(0, 2, d);
        finish_frame(0, 1'b0, d, 2'd0);

        start_frame();
        run_frame(5, 1, 48'h1234);

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", {state, fe_start}, 4'd0);

        // Continuous-mode instance: one start, three frames.
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) begin
                pixel_valid = 1'b1;
                tick();
            end
            pixel_valid = 1'b0;
            fe_done = 1'b1;
            tick();
            fe_done  = 1'b0;
            buf_full = 1'b1;
            tick();
            buf_full = 1'b0;
            d = {16'($urandom), $urandom};
            fc_valid = 1'b1;
            fc_data  = d;
            tick();
            fc_valid = 1'b0;
            check("auto_out", {res_valid_a, res_status_a, res_data_a}, {1'b1, 2'd0, d});
            if (f == 2) begin
                #1;
                check("auto_fe_pulses", fe_pulses_a, 3);
            end
            tick();
            check("auto_frames", {frame_cnt_a, state_a}, {16'(f + 1), 3'd1});
        end
        abort = 1'b1;
        tick();
        abort   = 1'b0;
        ready_a = 1'b0;
        check("auto_abort", {state_a, frame_cnt_a}, {3'd0, 16'd3});
        check("main_untouched", {state, frame_cnt}, {3'd0, 16'(exp_frames)});

        // Asynchronous reset while waiting for the buffer.
        start_frame();
        run_frame(4, 0, '0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {fe_start, fc_start, res_valid, res_data, res_status, feat_cnt,
                              frame_cnt, busy, state}, 0);
        tick();
        tick();
        rst = 1'b0;
        exp_frames = 0;
        tick();
        d = {16'($urandom), $urandom};
        start_frame();
        run_frame(0, $urandom_range(0, 5), d);
        finish_frame(0, 1'b0, d, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
